cskipa_pipe: RTL

- Parametrised, pipelined carry-skip adder/subtractor. Successor to the fixed 4-bit carry-skip adder.
- WIDTH-bit operands are split into WIDTH/BLOCK skip blocks. Each block is evaluated in its own pipeline stage, so block k sees the carry registered out of block k-1.
- Valid/ready handshake on both sides; full throughput of 1 op/cycle; backpressure stalls the pipe losslessly.
- Sits in the adder library as the throughput-oriented carry-skip variant for datapath integration.

---
 rtl/cskipa_pkg.sv | 29 ++
 rtl/cskipa_block.sv | 37 +++
 rtl/cskipa_pipe.sv | 133 +++++++++++++
 3 files changed

// File: rtl/cskipa_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cskipa_pkg
// Brief    : Shared definitions for the pipelined carry-skip adder/subtractor:
//            stage-count derivation, parameter legality check, stage record.
// Revision : 1.0 - initial release
// ============================================================================
package cskipa_pkg;

  // Number of skip blocks (and pipeline stages) for a given geometry.
  function automatic int calc_nb(input int width, input int block);
    return (block >= 1) ? (width / block) : 1;
  endfunction

  // Legal geometry: at least one bit per block, whole number of blocks.
  function automatic bit params_legal(input int width, input int block);
    return (block >= 1) && (width >= block) && ((width % block) == 0);
  endfunction

  // Per-stage control record. The wide fields (partial sum, pending
  // operands) live beside it because their width follows WIDTH.
  typedef struct packed {
    logic valid;    // stage holds a beat
    logic carry;    // carry out of the block this stage completed
    logic msb_cin;  // carry into the top bit of that block
  } stage_ctl_t;

endpackage
`default_nettype wire

// File: rtl/cskipa_block.sv
`default_nettype none
// ============================================================================
// Module   : cskipa_block
// Brief    : Combinational carry-skip block: BLOCK-bit ripple, group
//            propagate and skip mux on the carry out.
// Revision : 1.0 - initial release
// ============================================================================
module cskipa_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a_i,
  input  logic [BLOCK-1:0] b_i,
  input  logic             c_i,
  output logic [BLOCK-1:0] s_o,
  output logic             c_o,
  output logic             p_o,
  output logic             cmsb_o
);

  logic [BLOCK:0] w_c;

  // Ripple the block, then let the propagate term bypass the ripple carry.
  always_comb begin
    w_c    = '0;
    w_c[0] = c_i;
    s_o    = '0;
    for (int i = 0; i < BLOCK; i++) begin
      s_o[i]   = a_i[i] ^ b_i[i] ^ w_c[i];
      w_c[i+1] = (a_i[i] & b_i[i]) | (w_c[i] & (a_i[i] ^ b_i[i]));
    end
    p_o    = &(a_i ^ b_i);
    c_o    = p_o ? c_i : w_c[BLOCK];
    cmsb_o = w_c[BLOCK-1];
  end

endmodule
`default_nettype wire

// File: rtl/cskipa_pipe.sv
`default_nettype none
// ============================================================================
// Module   : cskipa_pipe
// Brief    : Pipelined carry-skip adder/subtractor, one skip block per stage,
//            valid/ready on both sides with lossless backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module cskipa_pipe
  import cskipa_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NB = calc_nb(WIDTH, BLOCK);

  if (!params_legal(WIDTH, BLOCK)) begin : g_param_err
    $error("cskipa_pipe: WIDTH must be a positive multiple of BLOCK");
  end

  stage_ctl_t       ctl_q [NB];
  logic [WIDTH-1:0] sum_q [NB];
  logic [WIDTH-1:0] a_q   [NB];
  logic [WIDTH-1:0] b_q   [NB];

  logic [NB:0]   w_ready;
  logic [NB-1:0] w_valid;
  logic [NB-1:0] w_prop;

  // A stage can take a beat when it is empty or its contents move on.
  always_comb begin
    w_ready[NB] = out_ready;
    for (int k = NB - 1; k >= 0; k--) begin
      w_ready[k] = ~w_valid[k] | w_ready[k+1];
    end
  end

  for (genvar k = 0; k < NB; k++) begin : g_stage
    logic [WIDTH-1:0] w_a_in;
    logic [WIDTH-1:0] w_b_in;
    logic [WIDTH-1:0] w_sum_in;
    logic             w_c_in;
    logic             w_v_in;
    logic [BLOCK-1:0] w_s;
    logic             w_cout;
    logic             w_cmsb;
    logic [WIDTH-1:0] sum_d;
    stage_ctl_t       ctl_d;
    logic             w_unused_bits;

    if (k == 0) begin : g_head
      // Subtraction is A + ~B + ~borrow, folded in before the first block.
      assign w_a_in   = in_a;
      assign w_b_in   = in_sub ? ~in_b : in_b;
      assign w_c_in   = in_sub ? ~in_cin : in_cin;
      assign w_sum_in = '0;
      assign w_v_in   = in_valid;
    end else begin : g_body
      assign w_a_in   = a_q[k-1];
      assign w_b_in   = b_q[k-1];
      assign w_c_in   = ctl_q[k-1].carry;
      assign w_sum_in = sum_q[k-1];
      assign w_v_in   = ctl_q[k-1].valid;
    end

    cskipa_block #(
      .BLOCK (BLOCK)
    ) u_blk (
      .a_i    (w_a_in[k*BLOCK +: BLOCK]),
      .b_i    (w_b_in[k*BLOCK +: BLOCK]),
      .c_i    (w_c_in),
      .s_o    (w_s),
      .c_o    (w_cout),
      .p_o    (w_prop[k]),
      .cmsb_o (w_cmsb)
    );

    // Merge this block's sum bits into the partial result travelling along.
    always_comb begin
      sum_d                    = w_sum_in;
      sum_d[k*BLOCK +: BLOCK]  = w_s;
      ctl_d.valid              = w_v_in;
      ctl_d.carry              = w_cout;
      ctl_d.msb_cin            = w_cmsb;
    end

    // Advance on ready; data only changes when a real beat arrives.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ctl_q[k] <= '0;
        sum_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
      end else if (w_ready[k]) begin
        if (w_v_in) begin
          ctl_q[k] <= ctl_d;
          sum_q[k] <= sum_d;
          a_q[k]   <= w_a_in;
          b_q[k]   <= w_b_in;
        end else begin
          ctl_q[k].valid <= 1'b0;
        end
      end
    end

    assign w_valid[k] = ctl_q[k].valid;

    // Consumed operand bits and the probe-only propagate flag go nowhere.
    assign w_unused_bits = ^{a_q[k], b_q[k], ctl_q[k].msb_cin, w_prop[k]};
  end

  assign in_ready  = w_ready[0];
  assign out_valid = ctl_q[NB-1].valid;
  assign out_sum   = sum_q[NB-1];
  assign out_cout  = ctl_q[NB-1].carry;
  assign out_ovf   = ctl_q[NB-1].carry ^ ctl_q[NB-1].msb_cin;

endmodule
`default_nettype wire
